// File: rtl/morse_pkg.sv
// Shared symbol codes, ASCII constants and the Morse code table for the character decoder.
// Digit entries are compiled in only when MORSE_DIGITS_EN is defined.
package morse_pkg;

  localparam logic [2:0] SYM_WAIT  = 3'd0;
  localparam logic [2:0] SYM_DIT   = 3'd1;
  localparam logic [2:0] SYM_DAH   = 3'd2;
  localparam logic [2:0] SYM_GAP   = 3'd3;
  localparam logic [2:0] SYM_SPACE = 3'd4;

  localparam logic [7:0] ASCII_QMARK = 8'h3F;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  // Longest code in the table; element bits are shifted in MSB-first, DIT=0, DAH=1.
  localparam int CODE_W = 5;

  typedef struct packed {
    logic       hit;
    logic [7:0] ascii;
  } lookup_t;

  // Bits of code above cnt are always zero, so {cnt, code} is a unique key.
  function automatic lookup_t morse_lookup(input logic [7:0] cnt, input logic [CODE_W-1:0] code);
    logic [7:0] a;
    a = 8'h00;
    case ({cnt, code})
      {8'd1, 5'b00000}: a = "E";
      {8'd1, 5'b00001}: a = "T";
      {8'd2, 5'b00000}: a = "I";
      {8'd2, 5'b00001}: a = "A";
      {8'd2, 5'b00010}: a = "N";
      {8'd2, 5'b00011}: a = "M";
      {8'd3, 5'b00000}: a = "S";
      {8'd3, 5'b00001}: a = "U";
      {8'd3, 5'b00010}: a = "R";
      {8'd3, 5'b00011}: a = "W";
      {8'd3, 5'b00100}: a = "D";
      {8'd3, 5'b00101}: a = "K";
      {8'd3, 5'b00110}: a = "G";
      {8'd3, 5'b00111}: a = "O";
      {8'd4, 5'b00000}: a = "H";
      {8'd4, 5'b00001}: a = "V";
      {8'd4, 5'b00010}: a = "F";
      {8'd4, 5'b00100}: a = "L";
      {8'd4, 5'b00110}: a = "P";
      {8'd4, 5'b00111}: a = "J";
      {8'd4, 5'b01000}: a = "B";
      {8'd4, 5'b01001}: a = "X";
      {8'd4, 5'b01010}: a = "C";
      {8'd4, 5'b01011}: a = "Y";
      {8'd4, 5'b01100}: a = "Z";
      {8'd4, 5'b01101}: a = "Q";
`ifdef MORSE_DIGITS_EN
      {8'd5, 5'b11111}: a = "0";
      {8'd5, 5'b01111}: a = "1";
      {8'd5, 5'b00111}: a = "2";
      {8'd5, 5'b00011}: a = "3";
      {8'd5, 5'b00001}: a = "4";
      {8'd5, 5'b00000}: a = "5";
      {8'd5, 5'b10000}: a = "6";
      {8'd5, 5'b11000}: a = "7";
      {8'd5, 5'b11100}: a = "8";
      {8'd5, 5'b11110}: a = "9";
`endif
      default: a = 8'h00;
    endcase
    return '{hit: (a != 8'h00), ascii: a};
  endfunction

endpackage

// File: rtl/morse_char_fifo.sv
// Small synchronous character FIFO; a push into a full FIFO is accepted only when a pop frees
// a slot on the same edge, otherwise it is discarded and drop_o pulses for one cycle.
module morse_char_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             drop_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             drop_q;
  logic             popOk, writeOk;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign popOk   = pop_i & ~empty_o;
  assign writeOk = push_i & (~full_o | popOk);
  assign data_o  = empty_o ? '0 : mem_q[rptr_q];
  assign drop_o  = drop_q;

  always_comb begin
    count_d = count_q;
    case ({writeOk, popOk})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      if (writeOk) begin
        mem_q[wptr_q] <= data_i;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (popOk) rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
      drop_q  <= push_i & full_o & ~popOk;
    end
  end

endmodule

// File: rtl/morse_char_decoder.sv
// Accumulates DIT/DAH elements, decodes on GAP/SPACE and queues ASCII characters for the sink.
// Define MORSE_DIGITS_EN to add digits 0-9 to the decode table.
module morse_char_decoder
  import morse_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter int         MAX_ELEMS  = 6,
  parameter logic [7:0] ERR_CHAR   = ASCII_QMARK,
  parameter logic [7:0] SPACE_CHAR = ASCII_SPACE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] inputSignal,
  output logic [7:0] out_char,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       code_err,
  output logic       drop
);

  localparam int              CNT_W   = $clog2(MAX_ELEMS + 2);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_ELEMS + 1);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_ACCUM    = 2'd1;
  localparam logic [1:0] ST_SPC_PEND = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              lastSpace_q, lastSpace_d;
  logic              codeErr_q, codeErr_d;
  logic              pushEn;
  logic [7:0]        pushChar;
  logic              fifoFull, fifoEmpty;
  lookup_t           lk;
  logic              letterErr;
  logic [7:0]        letterChar;

  // A saturated count means the code ran past MAX_ELEMS and its bits are no longer meaningful.
  assign lk         = morse_lookup(8'(cnt_q), code_q);
  assign letterErr  = (cnt_q == CNT_SAT) | ~lk.hit;
  assign letterChar = letterErr ? ERR_CHAR : lk.ascii;

  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    cnt_d       = cnt_q;
    lastSpace_d = lastSpace_q;
    codeErr_d   = 1'b0;
    pushEn      = 1'b0;
    pushChar    = 8'h00;
    if (state_q == ST_SPC_PEND) begin
      pushEn      = 1'b1;
      pushChar    = SPACE_CHAR;
      lastSpace_d = 1'b1;
      state_d     = ST_IDLE;
    end else begin
      case (inputSignal)
        SYM_DIT, SYM_DAH: begin
          code_d  = {code_q[CODE_W-2:0], inputSignal == SYM_DAH};
          if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
          state_d = ST_ACCUM;
        end
        SYM_GAP, SYM_SPACE: begin
          if (cnt_q != '0) begin
            pushEn      = 1'b1;
            pushChar    = letterChar;
            codeErr_d   = letterErr;
            lastSpace_d = 1'b0;
            cnt_d       = '0;
            code_d      = '0;
            state_d     = (inputSignal == SYM_SPACE) ? ST_SPC_PEND : ST_IDLE;
          end else if ((inputSignal == SYM_SPACE) && !lastSpace_q) begin
            pushEn      = 1'b1;
            pushChar    = SPACE_CHAR;
            lastSpace_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      code_q      <= '0;
      cnt_q       <= '0;
      lastSpace_q <= 1'b0;
      codeErr_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      cnt_q       <= cnt_d;
      lastSpace_q <= lastSpace_d;
      codeErr_q   <= codeErr_d;
    end
  end

  morse_char_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(8)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push_i (pushEn),
    .data_i (pushChar),
    .pop_i  (out_ready),
    .data_o (out_char),
    .full_o (fifoFull),
    .empty_o(fifoEmpty),
    .drop_o (drop)
  );

  assign out_valid = ~fifoEmpty;
  assign busy      = (cnt_q != '0) | (state_q == ST_SPC_PEND);
  assign code_err  = codeErr_q;

endmodule
